// File: rtl/mopshub_seq_pkg.sv
// Shared state encoding and default timing constants for the mopshub test-phase sequencer.
package mopshub_seq_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RX_RUN   = 4'd1,
        RX_FLUSH = 4'd2,
        GAP      = 4'd3,
        TX_RUN   = 4'd4,
        ADV_RUN  = 4'd5,
        DONE     = 4'd6,
        TIMEOUT  = 4'd7
    } seq_state_t;

    localparam int GAP_CYCLES_DEF     = 120;
    localparam int TIMEOUT_CYCLES_DEF = 2000000;

endpackage

// File: rtl/seq_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module seq_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_40_m,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mopshub_test_sequencer.sv
// Sequences the generator's RX, flush, gap, TX and optional advanced test phases after
// mopshub sign-on, with a shared per-phase timeout and per-phase cycle counters.
//
// state    | meaning
// IDLE     | waiting for sign_on_sig
// RX_RUN   | test_rx asserted until test_rx_end
// RX_FLUSH | one-cycle endwait_all pulse
// GAP      | GAP_CYCLES idle cycles before TX
// TX_RUN   | test_tx asserted until test_tx_end
// ADV_RUN  | test_advanced asserted until costum_msg_end
// DONE     | sequence complete, held until reset
// TIMEOUT  | a RUN phase overran, held until reset
module mopshub_test_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 32
) (
    input  logic             clk_40_m,
    input  logic             rst,
    input  logic             seq_abort,
    input  logic             trim_req,
    input  logic             end_power_init,
    input  logic             sign_on_sig,
    input  logic             test_rx_end,
    input  logic             test_tx_end,
    input  logic             costum_msg_end,
    input  logic             adv_en,
    output logic             osc_trim_en,
    output logic             test_rx,
    output logic             test_tx,
    output logic             test_advanced,
    output logic             endwait_all,
    output logic [3:0]       phase,
    output logic             seq_done,
    output logic             seq_timeout,
    output logic [CNT_W-1:0] rx_cycles,
    output logic [CNT_W-1:0] tx_cycles
);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] phase_cnt;
    logic             gap_hit, timeout_hit, in_run, seq_start;

    assign in_run      = (state == RX_RUN) || (state == TX_RUN) || (state == ADV_RUN);
    assign gap_hit     = (phase_cnt == CNT_W'(GAP_CYCLES - 1));
    assign timeout_hit = (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign seq_start   = (state == IDLE) && (state_next == RX_RUN);

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state       <= IDLE;
            seq_done    <= 1'b0;
            seq_timeout <= 1'b0;
            osc_trim_en <= 1'b0;
        end else begin
            state       <= state_next;
            seq_done    <= seq_done | (state_next == DONE);
            seq_timeout <= seq_timeout | (state_next == TIMEOUT);
            if (end_power_init) begin
                osc_trim_en <= 1'b0;
            end else if (trim_req) begin
                osc_trim_en <= 1'b1;
            end
        end
    end

    // End strobes are checked before the timeout so a strobe on the last allowed cycle completes the phase.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (sign_on_sig && !seq_done && !seq_timeout) state_next = RX_RUN;
            RX_RUN:   if (test_rx_end) state_next = RX_FLUSH;
                      else if (timeout_hit) state_next = TIMEOUT;
            RX_FLUSH: state_next = GAP;
            GAP:      if (gap_hit) state_next = TX_RUN;
            TX_RUN:   if (test_tx_end) state_next = adv_en ? ADV_RUN : DONE;
                      else if (timeout_hit) state_next = TIMEOUT;
            ADV_RUN:  if (costum_msg_end) state_next = DONE;
                      else if (timeout_hit) state_next = TIMEOUT;
            DONE:     state_next = DONE;
            TIMEOUT:  state_next = TIMEOUT;
            default:  state_next = IDLE;
        endcase
        if (seq_abort && (state != DONE) && (state != TIMEOUT)) begin
            state_next = IDLE;
        end
    end

    assign test_rx       = (state == RX_RUN);
    assign test_tx       = (state == TX_RUN);
    assign test_advanced = (state == ADV_RUN);
    assign endwait_all   = (state == RX_FLUSH);
    assign phase         = state;

    // Shared phase counter restarts on every state change; it times GAP and each RUN phase.
    seq_sat_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .clr      (state_next != state),
        .en       (in_run || (state == GAP)),
        .count    (phase_cnt)
    );

    seq_sat_counter #(.CNT_W(CNT_W)) u_rx_cnt (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .clr      (seq_start),
        .en       (state == RX_RUN),
        .count    (rx_cycles)
    );

    seq_sat_counter #(.CNT_W(CNT_W)) u_tx_cnt (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .clr      (seq_start),
        .en       (state == TX_RUN),
        .count    (tx_cycles)
    );

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Directed bench for mopshub_test_sequencer: one instance with default timing, one with a
// 100-cycle timeout, both driven from the same stimulus.
module tb_mopshub_test_sequencer;
    import mopshub_seq_pkg::*;

    logic        clk_40_m = 1'b0;
    logic        rst = 1'b0;
    logic        seq_abort = 1'b0, trim_req = 1'b0, end_power_init = 1'b0, sign_on_sig = 1'b0;
    logic        test_rx_end = 1'b0, test_tx_end = 1'b0, costum_msg_end = 1'b0, adv_en = 1'b0;

    logic        osc_trim_en, test_rx, test_tx, test_advanced, endwait_all, seq_done, seq_timeout;
    logic [3:0]  phase;
    logic [31:0] rx_cycles, tx_cycles;

    logic        t_osc_trim_en, t_test_rx, t_test_tx, t_test_advanced, t_endwait_all;
    logic        t_seq_done, t_seq_timeout;
    logic [3:0]  t_phase;
    logic [31:0] t_rx_cycles, t_tx_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk_40_m = ~clk_40_m;

    mopshub_test_sequencer dut (
        .clk_40_m(clk_40_m), .rst(rst), .seq_abort(seq_abort), .trim_req(trim_req),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig), .test_rx_end(test_rx_end),
        .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end), .adv_en(adv_en),
        .osc_trim_en(osc_trim_en), .test_rx(test_rx), .test_tx(test_tx),
        .test_advanced(test_advanced), .endwait_all(endwait_all), .phase(phase),
        .seq_done(seq_done), .seq_timeout(seq_timeout), .rx_cycles(rx_cycles), .tx_cycles(tx_cycles)
    );

    mopshub_test_sequencer #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk_40_m(clk_40_m), .rst(rst), .seq_abort(seq_abort), .trim_req(trim_req),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig), .test_rx_end(test_rx_end),
        .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end), .adv_en(adv_en),
        .osc_trim_en(t_osc_trim_en), .test_rx(t_test_rx), .test_tx(t_test_tx),
        .test_advanced(t_test_advanced), .endwait_all(t_endwait_all), .phase(t_phase),
        .seq_done(t_seq_done), .seq_timeout(t_seq_timeout), .rx_cycles(t_rx_cycles),
        .tx_cycles(t_tx_cycles)
    );

    task automatic step();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk_phase(input string tag, input logic [3:0] obs, input seq_state_t exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Enables must be mutually exclusive on every cycle for both instances.
    always @(negedge clk_40_m) begin
        if (rst) begin
            checks++;
            assert ($onehot0({test_rx, test_tx, test_advanced}) &&
                    $onehot0({t_test_rx, t_test_tx, t_test_advanced})) else begin
                errors++;
                $error("FAIL enable_overlap: observed rx/tx/adv=%b%b%b t=%b%b%b, expected at most one high",
                       test_rx, test_tx, test_advanced, t_test_rx, t_test_tx, t_test_advanced);
            end
        end
    end

    initial begin
        // reset state
        step(); step();
        chk_phase("rst_phase", phase, IDLE);
        chk_bit("rst_test_rx", test_rx, 1'b0);
        chk_bit("rst_endwait", endwait_all, 1'b0);
        chk_bit("rst_done", seq_done, 1'b0);
        chk_bit("rst_osc", osc_trim_en, 1'b0);
        chk("rst_rx_cycles", rx_cycles, 32'd0);
        chk("rst_tx_cycles", tx_cycles, 32'd0);
        rst = 1'b1;
        repeat (8) step();

        // nominal flow, adv_en=0
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        chk_bit("nom_rx_rise", test_rx, 1'b1);
        chk_phase("nom_phase_rx", phase, RX_RUN);
        repeat (39) step();
        chk_bit("nom_rx_c40", test_rx, 1'b1);
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        chk_bit("nom_rx_drop", test_rx, 1'b0);
        chk_bit("nom_endwait", endwait_all, 1'b1);
        chk_phase("nom_phase_flush", phase, RX_FLUSH);
        chk("nom_rx_cycles", rx_cycles, 32'd40);
        step();
        chk_bit("nom_endwait_single", endwait_all, 1'b0);
        chk_phase("nom_phase_gap", phase, GAP);
        repeat (119) step();
        chk_bit("nom_tx_not_yet", test_tx, 1'b0);
        step();
        chk_bit("nom_tx_rise", test_tx, 1'b1);
        chk_phase("nom_phase_tx", phase, TX_RUN);
        repeat (199) step();
        test_tx_end = 1'b1; step(); test_tx_end = 1'b0;
        chk_phase("nom_phase_done", phase, DONE);
        chk_bit("nom_done", seq_done, 1'b1);
        chk_bit("nom_tx_drop", test_tx, 1'b0);
        chk_bit("nom_adv_low", test_advanced, 1'b0);
        chk("nom_tx_cycles", tx_cycles, 32'd200);
        chk("nom_rx_kept", rx_cycles, 32'd40);
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0; step();
        chk_phase("nom_resign_ignored", phase, DONE);

        // advanced phase with spurious strobes
        rst = 1'b0; step(); rst = 1'b1; step();
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        test_tx_end = 1'b1; costum_msg_end = 1'b1; step(); test_tx_end = 1'b0; costum_msg_end = 1'b0;
        chk_phase("spur_phase_rx", phase, RX_RUN);
        chk_bit("spur_test_rx", test_rx, 1'b1);
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        step();
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        chk_phase("spur_gap_held", phase, GAP);
        repeat (119) step();
        chk_phase("adv_phase_tx", phase, TX_RUN);
        adv_en = 1'b1; test_tx_end = 1'b1; step(); test_tx_end = 1'b0;
        chk_bit("adv_rise", test_advanced, 1'b1);
        chk_bit("adv_tx_low", test_tx, 1'b0);
        chk_phase("adv_phase", phase, ADV_RUN);
        repeat (5) step();
        costum_msg_end = 1'b1; step(); costum_msg_end = 1'b0; adv_en = 1'b0;
        chk_bit("adv_drop", test_advanced, 1'b0);
        chk_phase("adv_phase_done", phase, DONE);
        chk_bit("adv_done", seq_done, 1'b1);

        // reset during GAP, restart, abort in TX_RUN
        rst = 1'b0; step(); rst = 1'b1; step();
        trim_req = 1'b1; step(); trim_req = 1'b0;
        chk_bit("trim_set", osc_trim_en, 1'b1);
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        repeat (4) step();
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        repeat (3) step();
        chk_phase("gaprst_in_gap", phase, GAP);
        rst = 1'b0; step();
        chk_phase("gaprst_phase", phase, IDLE);
        chk_bit("gaprst_tx", test_tx, 1'b0);
        chk_bit("gaprst_osc", osc_trim_en, 1'b0);
        chk("gaprst_rx_cycles", rx_cycles, 32'd0);
        rst = 1'b1; step();
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        chk("restart_rx_c1", rx_cycles, 32'd0);
        repeat (9) step();
        chk("restart_rx_c10", rx_cycles, 32'd9);
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        chk("restart_rx_total", rx_cycles, 32'd10);
        repeat (121) step();
        chk_bit("abort_in_tx", test_tx, 1'b1);
        seq_abort = 1'b1; step(); seq_abort = 1'b0;
        chk_phase("abort_phase", phase, IDLE);
        chk_bit("abort_tx_low", test_tx, 1'b0);
        chk("abort_rx_kept", rx_cycles, 32'd10);
        chk("abort_tx_kept", tx_cycles, 32'd1);

        // oscillator trim: clear wins over set
        trim_req = 1'b1; step(); trim_req = 1'b0;
        chk_bit("trim_set2", osc_trim_en, 1'b1);
        trim_req = 1'b1; end_power_init = 1'b1; step(); trim_req = 1'b0; end_power_init = 1'b0;
        chk_bit("trim_both_clear", osc_trim_en, 1'b0);

        // timeout with TIMEOUT_CYCLES=100
        rst = 1'b0; step(); rst = 1'b1; step();
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        repeat (99) step();
        chk_bit("to_rx_c100", t_test_rx, 1'b1);
        step();
        chk_bit("to_rx_drop", t_test_rx, 1'b0);
        chk_phase("to_phase", t_phase, TIMEOUT);
        chk_bit("to_flag", t_seq_timeout, 1'b1);
        chk("to_rx_cycles", t_rx_cycles, 32'd100);
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0; step();
        chk_phase("to_late_end", t_phase, TIMEOUT);
        chk_bit("to_late_endwait", t_endwait_all, 1'b0);

        // end strobe on the exact timeout cycle
        rst = 1'b0; step(); rst = 1'b1; step();
        sign_on_sig = 1'b1; step(); sign_on_sig = 1'b0;
        repeat (99) step();
        test_rx_end = 1'b1; step(); test_rx_end = 1'b0;
        chk_phase("tie_phase", t_phase, RX_FLUSH);
        chk_bit("tie_endwait", t_endwait_all, 1'b1);
        chk_bit("tie_no_timeout", t_seq_timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mopshub_test_sequencer.md
Name: mopshub_test_sequencer

Overview:
Synthesizable test-phase sequencer that drives the data generator's test-control inputs around mopshub_top_32bus. It sequences the phases after sign-on: RX test, end-wait flush, a programmable gap, TX test, then an optional custom-message (advanced) test. It enforces per-phase timeouts and reports per-phase cycle counts. It consumes the data generator's end strobes and mopshub's sign-on/power-init status, and produces test_rx/test_tx/test_advanced/endwait_all.

Parameters:
GAP_CYCLES, 120, idle cycles between the endwait_all pulse and test_tx assertion; legal range 1..65535.
TIMEOUT_CYCLES, 2000000, maximum cycles allowed in any RUN state before the sequencer aborts.
CNT_W, 32, width of the cycle counters and the timeout counter.

Ports:
clk_40_m  in  1  sequencer clock
rst  in  1  synchronous reset, active-low
seq_abort  in  1  level; forces return to IDLE
trim_req  in  1  pulse; requests oscillator auto-trim
end_power_init  in  1  mopshub power-init complete
sign_on_sig  in  1  mopshub sign-on done; starts the sequence
test_rx_end  in  1  generator RX test finished (pulse)
test_tx_end  in  1  generator TX test finished (pulse)
costum_msg_end  in  1  generator advanced test finished (pulse)
adv_en  in  1  run the advanced phase after TX; sampled on TX_RUN exit
osc_trim_en  out  1  drives osc_auto_trim_mopshub
test_rx  out  1  RX test enable
test_tx  out  1  TX test enable
test_advanced  out  1  custom-message test enable
endwait_all  out  1  single-cycle flush pulse to mopshub
phase  out  4  current state encoding (package enum)
seq_done  out  1  sticky; sequence completed
seq_timeout  out  1  sticky; a phase exceeded TIMEOUT_CYCLES
rx_cycles  out  CNT_W  cycles spent in RX_RUN
tx_cycles  out  CNT_W  cycles spent in TX_RUN

Behaviour:
- Reset: rst, synchronous, active-low; clock clk_40_m. While rst=0 every output is 0, phase=IDLE, and all counters are 0. Reset asserted mid-phase clears everything at the next edge; enables drop within 1 cycle.
- osc_trim_en: set on trim_req, cleared on end_power_init. If both are high in the same cycle, the clear wins. Independent of the FSM.
- States: IDLE, RX_RUN, RX_FLUSH, GAP, TX_RUN, ADV_RUN, DONE, TIMEOUT.
- IDLE -> RX_RUN: on sign_on_sig=1 while seq_done=0 and seq_timeout=0. test_rx goes high on the following edge (1-cycle latency) and stays high throughout RX_RUN.
- RX_RUN -> RX_FLUSH: on test_rx_end. test_rx drops on that edge.
- RX_FLUSH: lasts exactly 1 cycle, endwait_all=1, then -> GAP.
- GAP: count GAP_CYCLES cycles, then -> TX_RUN. test_tx rises exactly GAP_CYCLES+1 cycles after endwait_all rises.
- TX_RUN -> ADV_RUN if adv_en=1, else -> DONE, on test_tx_end.
- ADV_RUN -> DONE: on costum_msg_end.
- DONE: sets seq_done and holds until reset. A repeated sign_on_sig is ignored.
- Timeout: the shared phase counter resets on every RUN-state entry. Reaching TIMEOUT_CYCLES -> TIMEOUT: all enables drop, seq_timeout=1, terminal until reset.
- Timeout and end strobe in the same cycle: the end strobe wins.
- seq_abort=1 in any state except DONE/TIMEOUT -> IDLE next edge, enables cleared. Counters and sticky flags are retained.
- End strobes arriving outside their own RUN state are ignored. Examples: test_tx_end during RX_RUN; test_rx_end in GAP.
- rx_cycles/tx_cycles increment once per cycle in their RUN state and saturate at all-ones. Both are cleared on entry from IDLE.
- At most one of test_rx/test_tx/test_advanced is high at any time.

Decomposition:
- Package mopshub_seq_pkg holds:
  - typedef enum logic [3:0] seq_state_t, with IDLE=0, RX_RUN=1, RX_FLUSH=2, GAP=3, TX_RUN=4, ADV_RUN=5, DONE=6, TIMEOUT=7;
  - the default constants for GAP_CYCLES and TIMEOUT_CYCLES.
- One sub-module: seq_sat_counter, a CNT_W saturating counter with clear/enable. It is instantiated three times: rx_cycles, tx_cycles, and the phase/timeout/gap counter.

Test Plan:
- Nominal flow, adv_en=0: sign_on at cycle 10, test_rx_end at 50, test_tx_end 200 cycles after test_tx rises.
  - test_rx high cycles 11..50.
  - endwait_all pulse at 51.
  - test_tx rises at 172.
  - seq_done=1, rx_cycles=40, tx_cycles=200.
- Advanced phase, adv_en=1: test_advanced rises the cycle after test_tx_end and drops on costum_msg_end. seq_done=1, and there is never any overlap with test_tx.
- Timeout with TIMEOUT_CYCLES=100: withhold test_rx_end.
  - test_rx drops at cycle 100 of RX_RUN.
  - seq_timeout=1, phase=TIMEOUT.
  - A later test_rx_end leaves the state unchanged.
- Simultaneous events:
  - test_rx_end on the exact timeout cycle -> RX_FLUSH, seq_timeout=0.
  - trim_req and end_power_init together -> osc_trim_en=0.
- Reset and abort:
  - rst=0 during GAP -> all outputs 0 next edge; re-sign-on restarts the sequence with counters at 0.
  - seq_abort in TX_RUN -> IDLE, rx_cycles retained.
- Spurious strobes: test_tx_end and costum_msg_end pulses during RX_RUN -> no state change, test_rx stays 1.
